// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: loads win the register-file write port, ALU results
// bypass when idle or wait in an in-order queue that loads can partially cancel.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    input  logic [ADDR_W-1:0]          chk_rd,
    output logic                       chk_hit,
    output logic [$clog2(DEPTH):0]     q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  q_live;
    logic [ADDR_W-1:0] q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              alu_fire;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Handshake: an ALU result transfers on a cycle where alu_valid && alu_ready;
    // alu_ready comes from registered occupancy only, and mem_valid is never stalled.
    assign alu_ready = rst_n && (count < CW'(DEPTH));
    assign alu_fire  = alu_valid && alu_ready;
    assign pop       = !mem_valid && (count != '0);
    assign bypass    = !mem_valid && (count == '0) && alu_fire;
    assign push      = alu_fire && !bypass;
    assign q_count   = count;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = rf_waddr;
        sel_data = rf_wdata;
        if (mem_valid) begin
            sel_we   = 1'b1;
            sel_addr = mem_rd;
            sel_data = mem_data;
        end else if (pop) begin
            // A cancelled head is still popped but leaves the port idle.
            if (q_live[rd_ptr]) begin
                sel_we   = 1'b1;
                sel_addr = q_rd[rd_ptr];
                sel_data = q_data[rd_ptr];
            end
        end else if (bypass) begin
            sel_we   = 1'b1;
            sel_addr = alu_rd;
            sel_data = alu_data;
        end
    end

    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && q_live[idx] && (q_rd[idx] == chk_rd))
                chk_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            q_live   <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                q_rd[j]   <= '0;
                q_data[j] <= '0;
            end
        end else begin
            rf_we    <= sel_we && (sel_addr != '0);
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;

            // Queued writes are older than the load, so the load supersedes them.
            if (mem_valid) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (q_rd[j] == mem_rd)
                        q_live[j] <= 1'b0;
                end
            end
            // Same-cycle ALU push is younger than the load; this assignment wins.
            if (push) begin
                q_live[wr_ptr] <= 1'b1;
                q_rd[wr_ptr]   <= alu_rd;
                q_data[wr_ptr] <= alu_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the ALU result path and the memory-load return path at the write-back stage of the CPU. Memory loads (opcodes 0/1 in instruction[31:27]) have fixed priority. ALU results that lose arbitration are held in a small in-order queue and drained on idle cycles. The block preserves program-order semantics by cancelling queued ALU writes that an incoming load supersedes. It also exposes a pending-write lookup so decode can stall on RAW hazards.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 4, ALU queue depth (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result offered this cycle
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load data returning; must be written, never stalled
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)
- chk_rd  in  ADDR_W  register queried by decode
- chk_hit  out  1  comb: some live queue entry targets chk_rd
- q_count  out  $clog2(DEPTH)+1  queue occupancy, including cancelled entries

## Operation
- Queue: circular FIFO of DEPTH entries {live, rd, data}, with rd_ptr/wr_ptr wrapping modulo DEPTH and a count register.
- Per-cycle source select, in priority order:
  1. mem_valid=1 → write mem_rd/mem_data.
  2. Else count>0 → pop the head. If the head is live, write it. If it is cancelled, rf_we=0 that cycle.
  3. Else alu_valid=1 → bypass: write alu_rd/alu_data directly, with no queue push.
  4. Else rf_we=0; rf_waddr/rf_wdata hold their previous values.
- alu_ready = rst_n && (count < DEPTH). It depends only on registered state, with no combinational path from alu_valid or mem_valid.
- Handling an accepted ALU result that is not bypassed: push at wr_ptr with live=1.
  - The push is allowed in the same cycle as a pop. In that case count is unchanged.
  - A push into a full queue is impossible, because alu_ready=0 when full.
- Load supersede: when mem_valid=1, clear the live bit of every queued entry whose rd==mem_rd. These entries are older than the load.
  - An ALU result accepted in the same cycle is younger than the load, so it is pushed live and is not cancelled, even when alu_rd==mem_rd.
- Register 0: any selected write with address 0 is issued with rf_we=0. The pop or bypass still occurs.
- chk_hit = OR over i<count of (live[i] && rd[i]==chk_rd). A cancelled entry never hits.

## Timing
- Reset (asynchronous, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, count=0, pointers=0, all live=0, alu_ready=0, q_count=0. After release, alu_ready=1 in the same cycle.
- Latency from the winning input to rf_we/rf_waddr/rf_wdata is 1 cycle (the outputs are registered).
- Back-to-back loads starve the queue. Queued entries drain at 1 per cycle once mem_valid=0.
- Full queue combined with mem_valid: alu_ready=0; an ALU result offered that cycle is not accepted.
- Full queue and mem_valid=0: the pop frees a slot next cycle, so alu_ready=1 next cycle.
- Pointer wrap: wr_ptr/rd_ptr go from DEPTH-1 to 0 with no bubble.
- Reset asserted mid-drain discards all queued entries. No write is issued after rst_n falls.

## Test plan
- Bypass: queue empty, alu_valid with rd=3, data=0x11 → next cycle rf_we=1, waddr=3, wdata=0x11; q_count stays 0.
- Conflict: same cycle mem_valid (rd=4, 0xAA) and alu_valid (rd=5, 0xBB) → cycle+1 writes r4=0xAA; cycle+2 writes r5=0xBB; q_count is 1 between the two writes.
- Fill: hold mem_valid for 6 cycles while offering ALU results rd=1..6 → 4 accepted, alu_ready=0 once count=4. After mem_valid drops, r1..r4 are written in order on 4 consecutive cycles, then r5 and r6 are written as they are accepted.
- Supersede: queue holds live rd=7 (0x1). A load arrives with rd=7 (0x2) → r7=0x2 is written. The cancelled entry later pops with rf_we=0, and chk_rd=7 gives chk_hit=0 after the load cycle.
- Simultaneous same rd: mem_valid rd=9 (0x5) and alu_valid rd=9 (0x6) in the same cycle → r9=0x5 is written, then r9=0x6; the final value is 0x6.
- Async reset with 3 entries queued: pull rst_n low between clock edges → rf_we=0 and q_count=0 immediately. No queued write appears after release.
